cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Completion-side collector for the out-of-order core. It receives the single-cycle completion pulses (done/value/index) from the ALU, MUL and DIV exec pipeline registers and queues each source in its own small FIFO. It then broadcasts one completion per cycle on the common data bus (CDB) to the reservation stations and reorder buffer, using round-robin arbitration. Sources have no backpressure, so the block owns all buffering and overflow reporting.

## Interface
Parameters:
- DATA_W, 32, result value width
- IDX_W, 32, ROB/tag index width
- DEPTH, 4, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous pipeline flush (mispredict/exception)
- alu_exec_done  in  1  ALU completion pulse
- alu_exec_value  in  DATA_W  ALU result
- alu_exec_index  in  IDX_W  ALU tag
- mul_exec_done / mul_exec_value / mul_exec_index  in  1 / DATA_W / IDX_W  MUL completion
- div_exec_done / div_exec_value / div_exec_index  in  1 / DATA_W / IDX_W  DIV completion
- cdb_valid  out  1  broadcast valid, one cycle per completion
- cdb_value  out  DATA_W  broadcast result
- cdb_index  out  IDX_W  broadcast tag
- cdb_src  out  2  source of broadcast (0 ALU, 1 MUL, 2 DIV)
- overflow  out  3  sticky per-source drop flag, bit0 ALU, bit1 MUL, bit2 DIV

## Operation
- Each source has one FIFO. done=1 at a clock edge pushes {value,index} into it.
- Arbitration is combinational over the non-empty FIFO heads. Priority rotates, starting at the source after the last granted one. With no grant in a cycle, the pointer holds.
- The granted head is popped and registered onto the CDB at the same edge.
- cdb_valid=0 when all FIFOs are empty. cdb_value, cdb_index and cdb_src then hold their last values.
- Push to a full FIFO with no simultaneous pop: entry dropped, matching overflow bit set. The bit clears only on reset.
- Push to a full FIFO with a simultaneous pop of that FIFO: push accepted, count unchanged.
- Simultaneous pushes from all three sources are all accepted (independent FIFOs).
- flush=1: all FIFOs emptied, cdb_valid cleared at that edge, and any done inputs at that edge are dropped. overflow and the rr pointer are not affected.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - cdb_valid=0, cdb_value=0, cdb_index=0, cdb_src=0, overflow=0.
  - All FIFOs empty. The rr pointer gives ALU highest priority first, then MUL, then DIV.
- Latency: done sampled at edge E, earliest cdb_valid is after edge E+1. There is no same-cycle bypass.
- Throughput: one broadcast per cycle. Per-source throughput when all three sources are busy is 1/3.
- Reset mid-operation: immediate clear of all state, including queued entries.
- cdb_valid is a pulse. Consumers sample it every cycle, and there is no acknowledge.

## Structure
- Shared package cdb_pkg holds:
  - SRC_ALU=2'd0, SRC_MUL=2'd1, SRC_DIV=2'd2
  - NUM_SRC=3
  - the cdb entry struct {value, index}
- Sub-module cdb_src_fifo (params DATA_W, IDX_W, DEPTH):
  - ports push, push data, pop, flush, head data, empty, full, overflow
  - instantiated three times
- The top level contains only the rr arbiter, pointer update and CDB output registers.

## Test plan
- Reset, then ALU done with value 0x11, index 5 at edge 1 → cdb_valid=1 with value 0x11, index 5, src 0 after edge 2; cdb_valid=0 after edge 3.
- ALU, MUL and DIV done together at one edge (values 0xA/0xB/0xC) → three consecutive broadcasts in order src 0, 1, 2.
- Same simultaneous push as above issued twice in a row → grant order 0, 1, 2, 0, 1, 2, confirming the rr pointer advances and never starves a source.
- DIV done on 6 consecutive cycles while ALU and MUL each also push every cycle (DEPTH=4) → overflow[2]=1 once a DIV push hits full without a DIV pop. Broadcast DIV tags are in order with the dropped tags missing, and overflow stays 1 until reset.
- With 3 entries queued in MUL, flush and a simultaneous ALU done at edge E → cdb_valid=0 after E. No broadcasts follow, and the ALU entry is absent.
- Assert reset while entries are queued and cdb_valid=1 → all outputs return to 0 immediately. After release, a new ALU done is broadcast with 1-cycle latency.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared definitions for the completion data bus collector:
// source encodings, the queued entry layout and the round-robin step.
package cdb_pkg;

    localparam int NUM_SRC = 3;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MUL = 2'd1;
    localparam logic [1:0] SRC_DIV = 2'd2;

    localparam int CDB_DATA_W = 32;
    localparam int CDB_IDX_W  = 32;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] value;
        logic [CDB_IDX_W-1:0]  index;
    } cdb_entry_t;

    // Next source in rotation order ALU -> MUL -> DIV -> ALU.
    function automatic logic [1:0] rr_next(input logic [1:0] src);
        return (src == SRC_DIV) ? SRC_ALU : src + 2'd1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source completion FIFO. No backpressure toward the source: pushes into
// a full queue without a same-edge pop are dropped and flagged stickily.
module cdb_src_fifo #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_W+IDX_W-1:0] push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [DATA_W+IDX_W-1:0] head_data,
    output logic                    empty,
    output logic                    full,
    output logic                    overflow
);

    localparam int W     = DATA_W + IDX_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic push_ok;
    logic pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];
    assign overflow  = ovf_q;

    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & ~flush & (~full | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push & ~flush & full & ~pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB broadcast stage: queues ALU/MUL/DIV completions per source and issues
// one registered broadcast per cycle under round-robin priority.
import cdb_pkg::*;

module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alu_exec_done,
    input  logic [DATA_W-1:0] alu_exec_value,
    input  logic [IDX_W-1:0]  alu_exec_index,
    input  logic              mul_exec_done,
    input  logic [DATA_W-1:0] mul_exec_value,
    input  logic [IDX_W-1:0]  mul_exec_index,
    input  logic              div_exec_done,
    input  logic [DATA_W-1:0] div_exec_value,
    input  logic [IDX_W-1:0]  div_exec_index,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_value,
    output logic [IDX_W-1:0]  cdb_index,
    output logic [1:0]        cdb_src,
    output logic [2:0]        overflow
);

    localparam int W = DATA_W + IDX_W;

    logic [NUM_SRC-1:0] done_vec;
    logic [NUM_SRC-1:0] pop_vec;
    logic [NUM_SRC-1:0] empty_vec;
    logic [NUM_SRC-1:0] full_vec;
    logic [NUM_SRC-1:0] ovf_vec;
    logic [W-1:0]       push_data [NUM_SRC];
    logic [W-1:0]       head_data [NUM_SRC];
    logic [W-1:0]       head_sel;

    logic [1:0]        last_q, last_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [IDX_W-1:0]  cdb_index_q, cdb_index_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    logic       grant_any;
    logic [1:0] grant_src;
    logic [1:0] cand;
    logic       unused_full;

    assign done_vec     = {div_exec_done, mul_exec_done, alu_exec_done};
    assign push_data[0] = {alu_exec_value, alu_exec_index};
    assign push_data[1] = {mul_exec_value, mul_exec_index};
    assign push_data[2] = {div_exec_value, div_exec_index};
    assign unused_full  = ^full_vec;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
        cdb_src_fifo #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (done_vec[g]),
            .push_data (push_data[g]),
            .pop       (pop_vec[g]),
            .flush     (flush),
            .head_data (head_data[g]),
            .empty     (empty_vec[g]),
            .full      (full_vec[g]),
            .overflow  (ovf_vec[g])
        );
    end

    // Scan starts at the source after the last grant; a flush edge grants nothing.
    always_comb begin
        grant_any = 1'b0;
        grant_src = last_q;
        cand      = rr_next(last_q);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_any && !empty_vec[cand] && !flush) begin
                grant_any = 1'b1;
                grant_src = cand;
            end
            cand = rr_next(cand);
        end
    end

    always_comb begin
        pop_vec = '0;
        if (grant_any) begin
            pop_vec[grant_src] = 1'b1;
        end
    end

    assign head_sel = head_data[grant_src];

    always_comb begin
        last_d      = grant_any ? grant_src : last_q;
        cdb_valid_d = grant_any;
        cdb_value_d = grant_any ? head_sel[W-1:IDX_W] : cdb_value_q;
        cdb_index_d = grant_any ? head_sel[IDX_W-1:0] : cdb_index_q;
        cdb_src_d   = grant_any ? grant_src : cdb_src_q;
    end

    // Reset pointer sits at DIV so the first scan favours ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= SRC_DIV;
            cdb_valid_q <= 1'b0;
            cdb_value_q <= '0;
            cdb_index_q <= '0;
            cdb_src_q   <= SRC_ALU;
        end else begin
            last_q      <= last_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_value_q <= cdb_value_d;
            cdb_index_q <= cdb_index_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_value = cdb_value_q;
    assign cdb_index = cdb_index_q;
    assign cdb_src   = cdb_src_q;
    assign overflow  = ovf_vec;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts the
// registered CDB outputs every cycle; a negedge monitor compares them.
import cdb_pkg::*;

module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              alu_exec_done = 1'b0, mul_exec_done = 1'b0, div_exec_done = 1'b0;
    logic [DATA_W-1:0] alu_exec_value = '0, mul_exec_value = '0, div_exec_value = '0;
    logic [IDX_W-1:0]  alu_exec_index = '0, mul_exec_index = '0, div_exec_index = '0;
    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_value;
    logic [IDX_W-1:0]  cdb_index;
    logic [1:0]        cdb_src;
    logic [2:0]        overflow;

    cdb_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .alu_exec_done  (alu_exec_done),
        .alu_exec_value (alu_exec_value),
        .alu_exec_index (alu_exec_index),
        .mul_exec_done  (mul_exec_done),
        .mul_exec_value (mul_exec_value),
        .mul_exec_index (mul_exec_index),
        .div_exec_done  (div_exec_done),
        .div_exec_value (div_exec_value),
        .div_exec_index (div_exec_index),
        .cdb_valid      (cdb_valid),
        .cdb_value      (cdb_value),
        .cdb_index      (cdb_index),
        .cdb_src        (cdb_src),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] value;
        logic [31:0] index;
        logic [1:0]  src;
        logic [2:0]  ovf;
    } exp_t;

    exp_t       sb [$];
    cdb_entry_t mq [3][$];
    exp_t       cur;
    int         last_m;
    int         checks = 0;
    int         passes = 0;
    int         tag = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Reference model: each queue holds entries in arrival order; one grant per
    // edge goes to the first non-empty queue after the last granted source.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 3; s++) mq[s].delete();
            last_m = 2;
            cur    = '0;
            sb.delete();
            if (clk) sb.push_back(cur);
        end else begin
            logic [2:0] dn;
            cdb_entry_t din [3];
            dn     = {div_exec_done, mul_exec_done, alu_exec_done};
            din[0] = '{alu_exec_value, alu_exec_index};
            din[1] = '{mul_exec_value, mul_exec_index};
            din[2] = '{div_exec_value, div_exec_index};
            cur.valid = 1'b0;
            if (flush) begin
                for (int s = 0; s < 3; s++) mq[s].delete();
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    int s;
                    s = (last_m + k) % 3;
                    if (!cur.valid && mq[s].size() > 0) begin
                        cdb_entry_t e;
                        e = mq[s].pop_front();
                        cur.valid = 1'b1;
                        cur.value = e.value;
                        cur.index = e.index;
                        cur.src   = 2'(s);
                        last_m    = s;
                    end
                end
                for (int s = 0; s < 3; s++) begin
                    if (dn[s]) begin
                        if (mq[s].size() < DEPTH) mq[s].push_back(din[s]);
                        else cur.ovf[s] = 1'b1;
                    end
                end
            end
            sb.push_back(cur);
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("cdb_valid", 64'(cdb_valid), 64'(e.valid));
            chk("cdb_value", 64'(cdb_value), 64'(e.value));
            chk("cdb_index", 64'(cdb_index), 64'(e.index));
            chk("cdb_src",   64'(cdb_src),   64'(e.src));
            chk("overflow",  64'(overflow),  64'(e.ovf));
        end
    end

    task automatic put(input logic a, input logic [31:0] av, input logic [31:0] ai,
                       input logic m, input logic [31:0] mv, input logic [31:0] mi,
                       input logic d, input logic [31:0] dv, input logic [31:0] di,
                       input logic fl);
        @(negedge clk);
        alu_exec_done = a; alu_exec_value = av; alu_exec_index = ai;
        mul_exec_done = m; mul_exec_value = mv; mul_exec_index = mi;
        div_exec_done = d; div_exec_value = dv; div_exec_index = di;
        flush = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string tagname);
        chk({tagname, "_valid"}, 64'(cdb_valid), 64'd0);
        chk({tagname, "_value"}, 64'(cdb_value), 64'd0);
        chk({tagname, "_index"}, 64'(cdb_index), 64'd0);
        chk({tagname, "_src"},   64'(cdb_src),   64'd0);
        chk({tagname, "_ovf"},   64'(overflow),  64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int vcount;
        #1 reset = 1'b1;
        #1 check_zero("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single ALU completion: visible after the second edge, gone after the third.
        put(1, 32'h11, 32'd5, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        @(posedge clk); #1;
        chk("lat_valid", 64'(cdb_valid), 64'd1);
        chk("lat_value", 64'(cdb_value), 64'h11);
        chk("lat_index", 64'(cdb_index), 64'd5);
        chk("lat_src",   64'(cdb_src),   64'd0);
        @(posedge clk); #1;
        chk("lat_gone", 64'(cdb_valid), 64'd0);
        idle(3);

        // Simultaneous completions, single and back-to-back.
        do_reset();
        put(1, 32'hA, 32'd1, 1, 32'hB, 32'd2, 1, 32'hC, 32'd3, 0);
        idle(6);
        put(1, 32'hA, 32'd4, 1, 32'hB, 32'd5, 1, 32'hC, 32'd6, 0);
        put(1, 32'hA, 32'd7, 1, 32'hB, 32'd8, 1, 32'hC, 32'd9, 0);
        idle(10);

        // DIV overflow while all three sources stream.
        do_reset();
        for (int i = 0; i < 6; i++)
            put(1, 32'(i), 32'(200 + i), 1, 32'(i), 32'(300 + i), 1, 32'(i), 32'(100 + i), 0);
        idle(20);
        chk("ovf_div_sticky", 64'(overflow), 64'b100);

        // Flush with entries queued and a colliding ALU completion.
        do_reset();
        for (int i = 0; i < 3; i++)
            put(1, 32'(i), 32'(10 + i), 1, 32'(i), 32'(20 + i), 1, 32'(i), 32'(30 + i), 0);
        put(1, 32'hDEAD, 32'd99, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        #4; chk("flush_valid", 64'(cdb_valid), 64'd0);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (cdb_valid) vcount++;
        end
        chk("flush_no_bcast", 64'(vcount), 64'd0);

        // Reset while broadcasting.
        put(1, 32'h1, 32'd41, 1, 32'h2, 32'd42, 1, 32'h3, 32'd43, 0);
        idle(1);
        @(posedge clk); #1;
        chk("mid_valid_before", 64'(cdb_valid), 64'd1);
        reset = 1'b1;
        #1 check_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        put(1, 32'h77, 32'd8, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(cdb_valid), 64'd1);
        chk("post_rst_value", 64'(cdb_value), 64'h77);
        idle(3);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 500; i++) begin
            tag++;
            put(1'($urandom_range(0, 1)), $urandom, 32'(tag),
                1'($urandom_range(0, 1)), $urandom, 32'(tag + 1000),
                1'($urandom_range(0, 1)), $urandom, 32'(tag + 2000),
                1'($urandom_range(0, 31) == 0));
        end
        idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
